// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave, MSB first. The SPI pins are synchronised into clk and edge-detected there.
// Received words appear on rx_data with a one-cycle rx_valid pulse. The next reply word is staged in tx_buf.
module spi_slave_sync #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LED_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic [LED_W-1:0]  led
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Synchroniser stages; the *_dly_q copies exist only for edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_dly_q;
  logic ss_s1_q, ss_s2_q, ss_dly_q;
  logic mosi_s1_q, mosi_s2_q;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              rx_valid_q, rx_valid_d;
  logic [LED_W-1:0]  led_q, led_d;

  logic              sclk_rise, sclk_fall, ss_fall;
  logic [DATA_W-1:0] frame_word;

  assign sclk_rise = sclk_s2_q & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s2_q & sclk_dly_q;
  assign ss_fall   = ~ss_s2_q & ss_dly_q;

  // A load in the same cycle as a frame start must win over the stale buffer.
  assign frame_word = tx_load ? tx_data : tx_buf_q;

  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    rx_valid_d = 1'b0;
    led_d      = led_q;

    if (tx_load) begin
      tx_buf_d = tx_data;
    end

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d    = StShift;
          tx_shift_d = frame_word;
          bit_cnt_d  = '0;
        end
      end
      StShift: begin
        if (ss_s2_q) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s2_q};
          bit_cnt_d  = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntW'(DATA_W - 1)) begin
            // Outputs are registered here so they become visible together with the DONE cycle.
            state_d    = StDone;
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            led_d      = rx_shift_d[LED_W-1:0];
          end
        end else if (sclk_fall && (bit_cnt_q != '0)) begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
      StDone: begin
        bit_cnt_d = '0;
        if (!ss_s2_q) begin
          state_d    = StShift;
          tx_shift_d = frame_word;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_dly_q <= 1'b0;
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      ss_dly_q   <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      state_q    <= StIdle;
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      led_q      <= '0;
    end else begin
      sclk_s1_q  <= SCLK;
      sclk_s2_q  <= sclk_s1_q;
      sclk_dly_q <= sclk_s2_q;
      ss_s1_q    <= SS;
      ss_s2_q    <= ss_s1_q;
      ss_dly_q   <= ss_s2_q;
      mosi_s1_q  <= MOSI;
      mosi_s2_q  <= mosi_s1_q;
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_valid_q <= rx_valid_d;
      led_q      <= led_d;
    end
  end

  assign MISO     = ~ss_s2_q & tx_shift_q[DATA_W-1];
  assign busy     = (state_q != StIdle);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign led      = led_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync. It plays an SPI master aligned to the negative clk edge.
// Expected words come from a word-level model of the slave's buffers.
module tb_spi_slave_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SCLK = 1'b0;
  logic       SS = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic [5:0] led;

  int nvec = 0;
  int nerr = 0;
  int vcnt = 0;

  // Word-level model: last received word, staged reply word, expected pulse count.
  logic [7:0] m_rx = 8'h00;
  logic [7:0] m_txbuf = 8'h00;
  int         m_vcnt = 0;

  spi_slave_sync #(.DATA_W(8), .LED_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .SCLK     (SCLK),
    .SS       (SS),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .led      (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_valid === 1'b1) vcnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_tx(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    m_txbuf = v;
  endtask

  // One master frame; half = SCLK half-period in clk cycles (>= 4).
  task automatic frame(input logic [7:0] word, input int nbits, input int half, input bit keep_ss,
                       input int load_bit, input logic [7:0] load_val, input int rst_bit);
    logic [7:0] frame_tx;
    bit         full;
    full     = (nbits == 8) && (rst_bit < 0);
    frame_tx = m_txbuf;
    if (SS === 1'b1) begin
      @(negedge clk);
      SS = 1'b0;
      repeat (half) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      MOSI = word[7-i];
      if (i == rst_bit) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_rx    = 8'h00;
        m_txbuf = 8'h00;
        repeat (half - 1) @(negedge clk);
      end else if (i == load_bit) begin
        tx_data = load_val;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        m_txbuf = load_val;
        repeat (half - 1) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      if (rst_bit < 0) begin
        chk("miso_bit", MISO, frame_tx[7-i]);
        chk("busy_in_frame", busy, 1);
      end
      SCLK = 1'b1;
      if (full && i == 7) begin
        repeat (2) @(negedge clk);
        chk("rx_valid_early", rx_valid, 0);
        @(negedge clk);
        chk("rx_valid_pulse", rx_valid, 1);
        chk("rx_data_at_valid", rx_data, word);
        chk("led_at_valid", led, word[5:0]);
        @(negedge clk);
        chk("rx_valid_width", rx_valid, 0);
        if (keep_ss) chk("busy_between_frames", busy, 1);
        repeat (half - 4) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      SCLK = 1'b0;
    end
    if (full) begin
      m_rx = word;
      m_vcnt++;
    end
    if (!keep_ss) begin
      repeat (half) @(negedge clk);
      SS = 1'b1;
      repeat (half) @(negedge clk);
      chk("busy_idle", busy, 0);
      chk("miso_idle", MISO, 0);
    end
    chk("rx_data_hold", rx_data, m_rx);
    chk("led_hold", led, {26'd0, m_rx[5:0]});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_led", led, 0);
    chk("reset_miso", MISO, 0);

    load_tx(8'hA5);
    frame(8'h3C, 8, 5, 1'b0, -1, 8'h00, -1);
    chk("led_3c", led, 6'h3C);

    frame(8'h81, 8, 5, 1'b1, -1, 8'h00, -1);
    frame(8'h7E, 8, 5, 1'b0, -1, 8'h00, -1);
    chk("b2b_last", rx_data, 8'h7E);

    frame(8'hFF, 5, 5, 1'b0, -1, 8'h00, -1);
    chk("abort_keeps_rx", rx_data, 8'h7E);
    frame(8'h12, 8, 5, 1'b0, -1, 8'h00, -1);

    load_tx(8'hF0);
    frame(8'hAA, 8, 5, 1'b0, 3, 8'h55, -1);
    frame(8'h5A, 8, 5, 1'b0, -1, 8'h00, -1);

    frame(8'h99, 8, 5, 1'b0, -1, 8'h00, 4);
    chk("rst_mid_rx_data", rx_data, 0);
    frame(8'hC3, 8, 5, 1'b0, -1, 8'h00, -1);
    chk("after_rst_frame", rx_data, 8'hC3);

    for (int k = 0; k < 10; k++) begin
      logic [7:0] w;
      int         hp;
      int         nb;
      bit         keep;
      w    = 8'($urandom);
      hp   = int'($urandom_range(4, 8));
      nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
      keep = (nb == 8) && ($urandom_range(0, 1) == 1);
      if (SS === 1'b1 && $urandom_range(0, 1) == 1) load_tx(8'($urandom));
      if (SS === 1'b0 && nb != 8) nb = 8;
      frame(w, nb, hp, keep, -1, 8'h00, -1);
    end
    if (SS === 1'b0) begin
      repeat (5) @(negedge clk);
      SS = 1'b1;
      repeat (5) @(negedge clk);
    end

    for (int k = 0; k < 4; k++) begin
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
      SCLK = 1'b0;
      repeat (5) @(negedge clk);
    end
    chk("idle_sclk_busy", busy, 0);

    repeat (5) @(negedge clk);
    chk("valid_pulse_count", vcnt, m_vcnt);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 Parameter DATA_W, default 8, frame length in bits.
REQ-002 Parameter LED_W, default 6, width of the led display port.
REQ-003 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 SCLK  input  1  SPI serial clock from the master; asynchronous to clk.
REQ-006 SS  input  1  SPI slave select, active-low; asynchronous to clk.
REQ-007 MOSI  input  1  SPI data from the master; asynchronous to clk.
REQ-008 MISO  output  1  SPI data to the master.
REQ-009 tx_data  input  DATA_W  word to return in the next frame.
REQ-010 tx_load  input  1  one-cycle strobe that captures tx_data.
REQ-011 rx_data  output  DATA_W  last completely received word.
REQ-012 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-013 busy  output  1  high while a frame is in progress.
REQ-014 led  output  LED_W  rx_data[LED_W-1:0], registered.

Function
REQ-015 SCLK, SS and MOSI SHALL each pass through a 2-flop synchronizer into clk; all logic SHALL use only the synchronized copies.
REQ-016 Edge detection SHALL compare the synchronized value with its one-cycle-delayed copy and produce one-cycle sclk_rise, sclk_fall and ss_fall strobes.
REQ-017 Protocol SHALL be SPI mode 0, MSB first: MOSI sampled on SCLK rise, MISO changed on SCLK fall.
REQ-018 Supported operating range SHALL be an SCLK high time and low time of at least 4 clk periods each; behaviour outside this range is undefined.
REQ-019 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-020 IDLE -> SHIFT on ss_fall: load tx_shift from tx_buf, clear bit_cnt, assert busy.
REQ-021 In SHIFT, on sclk_rise: rx_shift <= {rx_shift[DATA_W-2:0], MOSI_sync} and bit_cnt increments.
REQ-022 In SHIFT, on sclk_fall with bit_cnt nonzero: tx_shift shifts left by one bit and bit 0 fills with 0.
REQ-023 SHIFT -> DONE on the sclk_rise that makes bit_cnt equal DATA_W.
REQ-024 DONE SHALL last exactly one cycle: rx_data <= rx_shift, rx_valid = 1, led updates, then go to SHIFT if SS_sync is low, otherwise IDLE.
REQ-025 Back-to-back frames with SS held low SHALL reload tx_shift from tx_buf on the DONE -> SHIFT transition.
REQ-026 rx_valid latency SHALL be exactly 1 clk after the cycle in which the final sclk_rise is detected.
REQ-027 MISO SHALL equal tx_shift[DATA_W-1] while SS_sync is low, and 0 while SS_sync is high.
REQ-028 tx_load SHALL write tx_buf at any time; a load during a frame SHALL NOT affect the current frame and SHALL take effect at the next frame start.
REQ-029 If tx_load and a frame start occur in the same cycle, tx_shift SHALL take the new tx_data.
REQ-030 If SS_sync rises in SHIFT before DATA_W bits are received, the FSM SHALL return to IDLE with no rx_valid; rx_data, led and tx_buf are unchanged, and bit_cnt clears.
REQ-031 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-032 SCLK edges while in IDLE SHALL be ignored.

Reset
REQ-033 While rst is high, at the next clk edge: state = IDLE, rx_data = 0, tx_buf = 0, rx_shift = 0, tx_shift = 0, bit_cnt = 0, rx_valid = 0, busy = 0, led = 0, MISO = 0, and the synchronizers are set to idle levels (SCLK 0, SS 1, MOSI 0).
REQ-034 rst asserted mid-frame SHALL abort the frame without an rx_valid; after rst is released, the slave SHALL wait for a new ss_fall.

Verification
REQ-035 Hold rst 3 cycles, then release -> all outputs are 0, busy = 0, MISO = 0.
REQ-036 tx_load with tx_data = 8'hA5; master sends 8'h3C with SCLK period 100 ns (clk 10 ns) -> MISO carries 1,0,1,0,0,1,0,1; a single rx_valid pulse 1 cycle after the 8th rise detect; rx_data = 8'h3C; led = 6'h3C.
REQ-037 Two back-to-back frames 8'h81 then 8'h7E with SS held low -> two rx_valid pulses; rx_data ends at 8'h7E; busy stays high between the frames.
REQ-038 SS raised after 5 bits of 8'hFF -> no rx_valid; rx_data keeps its previous value; the next full frame 8'h12 yields rx_data = 8'h12.
REQ-039 tx_load 8'h55 issued mid-frame while tx_buf = 8'hF0 -> the current frame returns F0 on MISO; the next frame returns 55.
REQ-040 rst pulsed at bit 4 of a frame -> rx_valid is never asserted; rx_data = 0; the next full frame 8'hC3 is received correctly.
